// File: rtl/seven_seg_display.sv
// Four-digit multiplexed seven-segment driver for an mm.ss clock.
// A prescaler produces a refresh tick; each tick advances the scan position, and the
// registered anode/cathode/dp outputs switch to that position on the same edge.
// Digits are snapshotted once per frame, on the tick that wraps the scan back to
// position 0, so a frame never shows a mix of old and new digits.
// In adjust mode the selected digit pair blinks at a rate derived from the tick.

module seven_seg_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minutes_top_digit,
  input  logic [3:0] minutes_bot_digit,
  input  logic [3:0] seconds_top_digit,
  input  logic [3:0] seconds_bot_digit,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(REFRESH_DIV - 1);
  localparam logic [BlkW-1:0] BlkMax = BlkW'(BLINK_DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic [BlkW-1:0] blk_q, blk_d;
  logic            phase_q, phase_d;
  logic [1:0]      idx_q, idx_d;
  // Packed as {minutes_top, minutes_bot, seconds_top, seconds_bot}: nibble n is position n.
  logic [15:0]     snap_q, snap_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            dp_q, dp_d;

  logic            tick;
  logic            wrap;
  logic            blank;
  logic [3:0]      digit;
  logic [6:0]      seg_dec;

  // Next-state: prescaler, scan index, frame snapshot, blink state and output registers.
  always_comb begin
    tick    = (pre_q == PreMax);
    pre_d   = tick ? '0 : pre_q + PreW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    wrap    = tick && (idx_q == 2'd3);
    snap_d  = wrap ? {minutes_top_digit, minutes_bot_digit,
                      seconds_top_digit, seconds_bot_digit} : snap_q;

    // Leaving adjust mode clears blink state on any cycle, not only on ticks.
    blk_d   = blk_q;
    phase_d = phase_q;
    if (!adj) begin
      blk_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (blk_q == BlkMax) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + BlkW'(1);
      end
    end

    // snap_d already holds the fresh capture on the wrapping tick, so position 0 sees it.
    digit = snap_d[{idx_d, 2'b00} +: 4];

    case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase

    // Positions 2,3 are minutes (idx[1]=1), matching sel=1.
    blank = adj && phase_q && (idx_d[1] == sel);

    seg_d = seg_q;
    an_d  = an_q;
    dp_d  = dp_q;
    if (tick) begin
      seg_d = blank ? 7'b1111111 : seg_dec;
      an_d  = ~(4'b0001 << idx_d);
      dp_d  = (idx_d != 2'd2);
    end
  end

  // State registers with asynchronous active-low reset; index parks at 3 so the
  // first tick wraps to 0 and captures the digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
      idx_q   <= 2'd3;
      snap_q  <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_display.sv
// Scoreboard bench for seven_seg_display with a small refresh/blink divider.
// A reference model counts clocks since reset release, derives tick number, scan
// position, frame snapshot and blink phase arithmetically, and queues the expected
// display state; a monitor pops an entry whenever the DUT outputs change.

module tb_seven_seg_display;

  localparam int unsigned RD = 4;
  localparam int unsigned BD = 2;

  localparam logic [6:0] SegTbl [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mt, mb, st, sb;
  logic       adj, sel;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t q[$];

  seven_seg_display #(
    .REFRESH_DIV(RD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .minutes_top_digit(mt),
    .minutes_bot_digit(mb),
    .seconds_top_digit(st),
    .seconds_bot_digit(sb),
    .adj              (adj),
    .sel              (sel),
    .seg              (seg),
    .an               (an),
    .dp               (dp)
  );

  always #5 clk = ~clk;

  // Reference model: one expected display state per refresh tick.
  initial begin
    int         blink_n;
    int         pos;
    logic [3:0] snap [4];
    logic [3:0] d;
    logic       blank;
    exp_t       e;
    blink_n = 0;
    for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        cyc     = 0;
        blink_n = 0;
        q.delete();
      end else begin
        cyc++;
        if (!adj) blink_n = 0;
        if (cyc % RD == 0) begin
          pos = ((cyc / RD) - 1) % 4;
          if (pos == 0) begin
            snap[0] = sb;
            snap[1] = st;
            snap[2] = mb;
            snap[3] = mt;
          end
          blank = 1'b0;
          if (adj) begin
            blank = (sel == (pos >= 2)) && (((blink_n / BD) % 2) == 1);
            blink_n++;
          end
          d     = snap[pos];
          e.seg = (blank || d > 4'd9) ? 7'b1111111 : SegTbl[d];
          e.an  = ~(4'b0001 << pos);
          e.dp  = (pos != 2);
          e.cyc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  // Monitor: any output change must match the oldest queued expectation, on time.
  initial begin
    logic [11:0] prev;
    exp_t        e;
    prev = {4'hf, 7'h7f, 1'b1};
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        prev = {4'hf, 7'h7f, 1'b1};
      end else begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL overdue_update: expected an=%b seg=%b dp=%b at cycle %0d, still pending at %0d",
                   e.an, e.seg, e.dp, e.cyc, cyc);
        end
        if ({an, seg, dp} != prev) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_update: got an=%b seg=%b dp=%b at cycle %0d, none due",
                     an, seg, dp, cyc);
          end else begin
            e = q.pop_front();
            if ({an, seg, dp} !== {e.an, e.seg, e.dp} || e.cyc != cyc) begin
              n_bad++;
              $display("FAIL tick_update: got an=%b seg=%b dp=%b cyc=%0d, want an=%b seg=%b dp=%b cyc=%0d",
                       an, seg, dp, cyc, e.an, e.seg, e.dp, e.cyc);
            end
          end
          prev = {an, seg, dp};
        end
      end
    end
  end

  task automatic check_direct(input string name, input logic [11:0] act, input logic [11:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got {an,seg,dp}=%b want %b", name, act, want);
    end
  endtask

  task automatic wait_an(input logic [3:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an == target) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL wait_an: got an=%b want %b within 64 cycles", an, target);
    end
  endtask

  // Stimulus; inputs change only at falling edges.
  initial begin
    rst = 1'b0;
    {mt, mb, st, sb} = 16'h0000;
    adj = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    check_direct("reset_state", {an, seg, dp}, {4'hf, 7'h7f, 1'b1});

    mt = 4'd1; mb = 4'd2; st = 4'd3; sb = 4'd4;
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (8 * RD) @(negedge clk);

    // Change seconds_bot while position 1 is lit: shows only after the next wrap.
    wait_an(4'b1101);
    sb = 4'd7;
    repeat (8 * RD) @(negedge clk);

    // Non-BCD value blanks its segments but keeps the anode.
    st = 4'hA;
    repeat (8 * RD) @(negedge clk);
    st = 4'd5;

    // Blinking: seconds pair, then minutes pair, then off.
    adj = 1'b1;
    sel = 1'b0;
    repeat (16 * RD) @(negedge clk);
    sel = 1'b1;
    repeat (8 * RD) @(negedge clk);
    adj = 1'b0;
    repeat (8 * RD) @(negedge clk);

    // Random digits and mode changes at arbitrary cycles.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: mt = 4'($urandom_range(0, 15));
          1: mb = 4'($urandom_range(0, 15));
          2: st = 4'($urandom_range(0, 15));
          default: sb = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 29) == 0) sel = ~sel;
    end
    adj = 1'b0;

    // Mid-scan asynchronous reset, checked before any clock edge.
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_direct("async_reset_mid_scan", {an, seg, dp}, {4'hf, 7'h7f, 1'b1});
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // Restart after reset and run well past 20 ticks to confirm spacing.
    mt = 4'd9; mb = 4'd8; st = 4'd0; sb = 4'd6;
    repeat (24 * RD) @(negedge clk);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_display.md
SEVEN_SEG_DISPLAY -- requirements
Module: seven_seg_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per refresh tick (min 2).
REQ-002 SHALL have parameter BLINK_DIV, default 250, meaning refresh ticks per blink half-period (min 1).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port minutes_top_digit  input  4  BCD tens of minutes.
REQ-006 SHALL have port minutes_bot_digit  input  4  BCD units of minutes.
REQ-007 SHALL have port seconds_top_digit  input  4  BCD tens of seconds.
REQ-008 SHALL have port seconds_bot_digit  input  4  BCD units of seconds.
REQ-009 SHALL have port adj  input  1  adjust mode, enables blinking of selected pair.
REQ-010 SHALL have port sel  input  1  blink pair select: 0 seconds, 1 minutes.
REQ-011 SHALL have port seg  output  7  cathodes, active-low, seg[0]=a ... seg[6]=g.
REQ-012 SHALL have port an  output  4  anodes, active-low, one-hot-low when lit.
REQ-013 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-014 SHALL run a prescaler counting 0..REFRESH_DIV-1, asserting internal tick on the cycle count==REFRESH_DIV-1, then wrapping to 0.
REQ-015 SHALL hold a 2-bit scan index; on each tick index advances modulo 4 (3->0 wraps).
REQ-016 SHALL map index to position: 0 seconds_bot/an[0], 1 seconds_top/an[1], 2 minutes_bot/an[2], 3 minutes_top/an[3].
REQ-017 SHALL capture all four input digits into a snapshot register on the tick where index wraps 3->0; position 0 on that tick uses the newly captured value.
REQ-018 SHALL ignore input digit changes between wraps (no tearing within a scan frame).
REQ-019 SHALL register seg, an, dp; they update on the tick edge to reflect the new index, held otherwise (zero extra latency beyond that edge).
REQ-020 SHALL decode 0-9 to standard patterns (0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000).
REQ-021 SHALL output seg=7'b1111111 for digit values 10-15, anode still driven.
REQ-022 SHALL drive dp=0 only at position 2 (mm.ss separator), dp=1 elsewhere.
REQ-023 SHALL run a blink counter 0..BLINK_DIV-1 advancing on ticks while adj=1, toggling blink phase on wrap.
REQ-024 SHALL, when adj=1 and phase=1, force seg=7'b1111111 for positions of the selected pair (sel=0: 0,1; sel=1: 2,3); an and dp unaffected.
REQ-025 SHALL, when adj=0, clear blink counter and phase to 0 synchronously and never blank.
REQ-026 SHALL apply sel/adj changes at the next tick's output update only.

Reset
REQ-027 SHALL, on rst=0, immediately force an=4'b1111, seg=7'b1111111, dp=1, prescaler 0, blink counter/phase 0, snapshot 0, index 3.
REQ-028 SHALL, after rst release, produce first tick on the REFRESH_DIV-th rising edge, wrapping index to 0 and capturing digits.
REQ-029 SHALL allow reset assertion mid-frame; next frame restarts per REQ-028.

Verification (REFRESH_DIV=4, BLINK_DIV=2)
REQ-030 SHALL cover: rst=0 mid-scan -> an=1111, seg=1111111, dp=1 with no clock edge.
REQ-031 SHALL cover: digits mt=1,mb=2,st=3,sb=4 after reset -> ticks every 4 clocks give an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100/dp=0, an=0111/seg=1111001.
REQ-032 SHALL cover: seconds_bot 4->7 while index=1 -> positions 1-3 unchanged, position 0 shows 1111000 only after next wrap.
REQ-033 SHALL cover: seconds_top=4'hA -> seg=1111111 while an=1101.
REQ-034 SHALL cover: adj=1, sel=0 -> seconds positions blank on alternate pairs of ticks, minutes positions never blank; adj=0 -> no blanking.
REQ-035 SHALL cover: tick spacing exactly 4 clocks across 20 ticks, no skipped or duplicate anode.
